nibble_capture_fifo: RTL

- Receiving end for the 4-bit values our benches drive onto nets and variables.
- Captures nibbles from a write strobe into a small first-word-fall-through buffer.
- Drains them through a valid/ready read port.
- Keeps count, full/empty and a sticky overflow flag so a checker can consume values at its own pace.

---
 rtl/nibble_cap_pkg.sv | 13 +
 rtl/nibble_cap_mem.sv | 25 ++
 rtl/nibble_capture_fifo.sv | 114 +++++++++++
 3 files changed

// File: rtl/nibble_cap_pkg.sv
// rtl/nibble_cap_pkg.sv - shared widths, types and helpers for the nibble capture FIFO
package nibble_cap_pkg;

    localparam int NIBBLE_DW    = 4;
    localparam int NIBBLE_DEPTH = 8;

    typedef logic [3:0] nibble_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/nibble_cap_mem.sv
// rtl/nibble_cap_mem.sv - DEPTH x DW storage, registered write, combinational read
module nibble_cap_mem #(
    parameter int DW    = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/nibble_capture_fifo.sv
// rtl/nibble_capture_fifo.sv - first-word-fall-through nibble capture buffer with sticky overflow
// Optional NIBBLE_CHANGE_ONLY_EN: only push writes whose data differs from the last captured value.
module nibble_capture_fifo
    import nibble_cap_pkg::*;
#(
    parameter int DW    = NIBBLE_DW,
    parameter int DEPTH = NIBBLE_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    input  logic [DW-1:0]               wr_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [DW-1:0]               rd_data,
    output logic [cnt_w(DEPTH)-1:0]     count,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow,
    input  logic                        clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_full;
    logic          w_empty;
    logic          w_cand;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic [DW-1:0] w_mem_rdata;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

`ifdef NIBBLE_CHANGE_ONLY_EN
    logic [DW-1:0] r_last;
    logic          r_last_vld;

    // Case inequality so a move to or from X/Z still counts as a change.
    assign w_cand = wr_valid && (!r_last_vld || (wr_data !== r_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (w_push) begin
            r_last     <= wr_data;
            r_last_vld <= 1'b1;
        end
    end
`else
    assign w_cand = wr_valid;
`endif

    assign w_pop  = !w_empty && rd_ready;
    assign w_push = w_cand && (!w_full || w_pop);
    assign w_drop = w_cand && w_full && !w_pop;

    nibble_cap_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push && !rst),
        .i_waddr (r_wptr),
        .i_wdata (wr_data),
        .i_raddr (r_rptr),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Set takes priority over a coincident clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rd_valid = !w_empty;
    assign rd_data  = w_empty ? '0 : w_mem_rdata;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;

endmodule
